gmii_tx_framer: RTL and testbench
=================================

# gmii_tx_framer

Synthesizable GMII/MII transmit framer: accepts frame octets on a valid/ready stream and drives the MAC-to-PHY transmit bus with preamble, SFD, payload, optional padding and inter-frame gap. It sits between the transmit packet buffer and the SGMII PCS transmit path. It is the transmitting counterpart of the MAC receive model in the simulation environment, and its output must be accepted by that model in both byte (1000 Mb/s) and nibble (10/100 Mb/s) modes.

## Interface
- IFG_OCTETS, 12: idle octet-times between frames (min 1).
- PAD_EN, 1: pad short frames with 0x00.
- MIN_LEN, 60: minimum payload octets when PAD_EN=1 (1..65535).
- i_TxClk  in  1  transmit clock; all logic on its rising edge.
- i_Reset  in  1  asynchronous, active-high reset.
- i2_Speed  in  2  2'b10 = byte mode; any other value = nibble mode; sampled only on the IDLE→PREAMBLE transition.
- i8_Data  in  8  frame octet.
- i_Valid  in  1  i8_Data/i_Last/i_Err valid.
- i_Last  in  1  final octet of frame.
- i_Err  in  1  drive this octet with TxER.
- o_Ready  out  1  framer accepts the octet this cycle.
- o8_TxD  out  8  transmit data; nibble mode uses [3:0], [7:4]=0.
- o_TxEN  out  1  transmit enable.
- o_TxER  out  1  transmit error.
- o_Underrun  out  1  one-cycle pulse on mid-frame underrun.
- o16_TxFrames  out  16  completed non-aborted frames, wraps at 65535→0.

## Operation
- Accept = i_Valid & o_Ready. o_Ready is a combinational decode of state/phase.
- States: IDLE, PREAMBLE, DATA, PAD, DRAIN, IFG.
- IDLE: o_Ready=0. Outputs are TxEN=0, TxER=0, TxD=0. i_Valid=1 → latch speed mode, go to PREAMBLE. The first octet is not consumed.
- PREAMBLE: byte mode drives 7×0x55 then 0xD5 (8 cycles). Nibble mode drives 15×0x5 then 0xD (16 cycles). TxEN=1.
- DATA: each accepted octet is driven on the pins.
  - Byte mode: one cycle per octet.
  - Nibble mode: low nibble first, then high nibble.
  - i_Err=1 sets TxER=1 for that octet's cycles. TxEN stays 1.
  - The 16-bit length counter increments per octet and saturates at 65535.
- Last octet accepted with PAD_EN=1 and count<MIN_LEN → PAD state, which emits 0x00 octets until count=MIN_LEN, then goes to IFG. Otherwise the next state is IFG.
- Underrun: o_Ready=1 and i_Valid=0 in DATA.
  - Pulse o_Underrun.
  - Drive one octet-time with TxEN=1, TxER=1, TxD=0.
  - Go to DRAIN: o_Ready=1, TxEN=0, octets discarded until an accept with i_Last=1, then go to IFG.
  - An aborted frame does not increment o16_TxFrames.
- IFG: TxEN=0 for IFG_OCTETS octet-times (nibble mode: 2·IFG_OCTETS cycles), then go to IDLE. o16_TxFrames increments on IFG entry for a non-aborted frame.
- A frame with i_Last on its first octet is legal: payload of 1 octet, padded if PAD_EN=1.
- i2_Speed changes mid-frame are ignored.

## Timing
- o8_TxD, o_TxEN and o_TxER are registered. All outputs are 0 and the state is IDLE while i_Reset=1. Reset mid-frame clears outputs immediately and loses the frame.
- Start-up sequence:
  - Cycle t0 in IDLE with i_Valid=1.
  - Preamble is on the pins from t1. Byte-mode SFD is at t8; nibble-mode SFD nibble is at t16.
- Byte mode ready/latency:
  - o_Ready=1 from the SFD cycle onward in DATA.
  - An octet accepted at cycle N appears on o8_TxD at N+1, with no gap between SFD and payload or between consecutive octets.
- Nibble mode ready/latency:
  - o_Ready=1 on the SFD cycle and on every high-nibble cycle.
  - An octet accepted at N drives its low nibble at N+1 and its high nibble at N+2.
- After the last payload or pad octet, TxEN falls at the next octet boundary. The earliest following preamble starts IFG_OCTETS octet-times plus one cycle (IDLE) later.

## Structure
- Shared package gmii_pkg holds:
  - state enum;
  - constants PREAMBLE_OCT=8'h55, SFD_OCT=8'hD5, SPEED_1000=2'b10.
- The same package is imported by the PCS transmit and receive blocks.
- Single module; no sub-module. The octet-time phase bit (nibble mode) and a shared 4-bit preamble/IFG counter are inline.

## Test plan
- Byte mode, 64-octet frame 0x00..0x3F, i_Valid held high → pins show 55×7, D5, 00..3F; TxEN high for 72 cycles; o16_TxFrames=1; the MAC receive model reports 64 bytes.
- Nibble mode (i2_Speed=2'b01), payload 0xA5,0x3C → nibbles 5×15, D, 5, A, C, 3, then PAD to 60 octets; the receive model reports 60 bytes.
- Back-to-back frames in byte mode with IFG_OCTETS=12 → exactly 12 TxEN-low cycles plus one IDLE cycle between the last octet and the next 0x55.
- Underrun after 10 octets of a 20-octet frame → one cycle TxEN=1/TxER=1/TxD=0, o_Underrun pulse, remaining 10 octets drained, o16_TxFrames unchanged.
- i_Err on octet 5 of a 64-octet frame → TxER=1 only on that octet's cycle (two cycles in nibble mode), data unchanged.
- Assert i_Reset during the DATA state → outputs 0 asynchronously; after release, a new frame transmits correctly.

Source files
------------

// File: rtl/gmii_pkg.sv
// Shared GMII transmit/receive definitions: framer state encoding and line constants.
package gmii_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_DATA,
      ST_PAD,
      ST_DRAIN,
      ST_IFG
   } txState_t;

   localparam logic [7:0] PREAMBLE_OCT = 8'h55;
   localparam logic [7:0] SFD_OCT      = 8'hD5;
   localparam logic [1:0] SPEED_1000   = 2'b10;

   function automatic logic [15:0] satInc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/gmii_tx_framer.sv
// GMII/MII transmit framer: wraps a valid/ready octet stream with preamble, SFD,
// optional zero padding and inter-frame gap; byte (1000) or nibble (10/100) pins.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | bus quiet, waiting for i_Valid; speed latched on exit
// ST_PREAMBLE | 7x55 + D5 (byte) or 15x5 + D (nibble), counted by cnt
// ST_DATA     | payload octets; ready on octet boundaries
// ST_PAD      | zero octets until length reaches MIN_LEN
// ST_DRAIN    | after underrun: swallow octets up to i_Last, TxEN low
// ST_IFG      | TxEN low for IFG_OCTETS octet-times, then back to idle
module gmii_tx_framer #(
   parameter int IFG_OCTETS = 12,
   parameter bit PAD_EN     = 1'b1,
   parameter int MIN_LEN    = 60
) (
   input  logic        i_TxClk,
   input  logic        i_Reset,
   input  logic [1:0]  i2_Speed,
   input  logic [7:0]  i8_Data,
   input  logic        i_Valid,
   input  logic        i_Last,
   input  logic        i_Err,
   output logic        o_Ready,
   output logic [7:0]  o8_TxD,
   output logic        o_TxEN,
   output logic        o_TxER,
   output logic        o_Underrun,
   output logic [15:0] o16_TxFrames
);
   import gmii_pkg::*;

   // The IFG count shares the 4-bit preamble counter, so IFG_OCTETS is 1..15.
   localparam logic [3:0]  IFG_LAST   = 4'(IFG_OCTETS);
   localparam logic [15:0] MIN_LEN16  = 16'(MIN_LEN);

   txState_t    state;
   logic        byteMode;
   logic        phase;
   logic [3:0]  cnt;
   logic [15:0] lenCnt;
   logic [3:0]  hiNib;
   logic        hiEn;
   logic        hiErr;

   logic        accept;
   logic [15:0] lenNext;
   logic [3:0]  preLast;

   assign o_Ready = ((state == ST_DATA) && !phase) || (state == ST_DRAIN);
   assign accept  = i_Valid & o_Ready;
   assign lenNext = satInc16(lenCnt);
   assign preLast = byteMode ? 4'd6 : 4'd14;

   always_ff @(posedge i_TxClk or posedge i_Reset) begin
      if (i_Reset) begin
         state        <= ST_IDLE;
         byteMode     <= 1'b0;
         phase        <= 1'b0;
         cnt          <= 4'd0;
         lenCnt       <= 16'd0;
         hiNib        <= 4'd0;
         hiEn         <= 1'b0;
         hiErr        <= 1'b0;
         o8_TxD       <= 8'd0;
         o_TxEN       <= 1'b0;
         o_TxER       <= 1'b0;
         o_Underrun   <= 1'b0;
         o16_TxFrames <= 16'd0;
      end else begin
         o_Underrun <= 1'b0;
         if (phase) begin
            // second half of a nibble-mode octet-time: replay the held high nibble
            o8_TxD <= {4'h0, hiNib};
            o_TxEN <= hiEn;
            o_TxER <= hiErr;
            phase  <= 1'b0;
            if ((state == ST_DRAIN) && accept && i_Last) begin
               state <= ST_IFG;
               cnt   <= 4'd0;
            end
         end else begin
            unique case (state)
               ST_IDLE: begin
                  o8_TxD <= 8'd0;
                  o_TxEN <= 1'b0;
                  o_TxER <= 1'b0;
                  if (i_Valid) begin
                     byteMode <= (i2_Speed == SPEED_1000);
                     o8_TxD   <= (i2_Speed == SPEED_1000) ? PREAMBLE_OCT
                                                          : {4'h0, PREAMBLE_OCT[3:0]};
                     o_TxEN   <= 1'b1;
                     cnt      <= 4'd0;
                     lenCnt   <= 16'd0;
                     state    <= ST_PREAMBLE;
                  end
               end
               ST_PREAMBLE: begin
                  o_TxEN <= 1'b1;
                  o_TxER <= 1'b0;
                  if (cnt == preLast) begin
                     o8_TxD <= byteMode ? SFD_OCT : {4'h0, SFD_OCT[7:4]};
                     state  <= ST_DATA;
                  end else begin
                     o8_TxD <= byteMode ? PREAMBLE_OCT : {4'h0, PREAMBLE_OCT[3:0]};
                     cnt    <= cnt + 4'd1;
                  end
               end
               ST_DATA: begin
                  if (i_Valid) begin
                     o8_TxD <= byteMode ? i8_Data : {4'h0, i8_Data[3:0]};
                     o_TxEN <= 1'b1;
                     o_TxER <= i_Err;
                     hiNib  <= i8_Data[7:4];
                     hiEn   <= 1'b1;
                     hiErr  <= i_Err;
                     phase  <= ~byteMode;
                     lenCnt <= lenNext;
                     if (i_Last) begin
                        if (PAD_EN && (lenNext < MIN_LEN16)) begin
                           state <= ST_PAD;
                        end else begin
                           state        <= ST_IFG;
                           cnt          <= 4'd0;
                           o16_TxFrames <= o16_TxFrames + 16'd1;
                        end
                     end
                  end else begin
                     // underrun: one poisoned octet-time, then discard the rest
                     o8_TxD     <= 8'd0;
                     o_TxEN     <= 1'b1;
                     o_TxER     <= 1'b1;
                     hiNib      <= 4'd0;
                     hiEn       <= 1'b1;
                     hiErr      <= 1'b1;
                     phase      <= ~byteMode;
                     o_Underrun <= 1'b1;
                     state      <= ST_DRAIN;
                  end
               end
               ST_PAD: begin
                  o8_TxD <= 8'd0;
                  o_TxEN <= 1'b1;
                  o_TxER <= 1'b0;
                  hiNib  <= 4'd0;
                  hiEn   <= 1'b1;
                  hiErr  <= 1'b0;
                  phase  <= ~byteMode;
                  lenCnt <= lenNext;
                  if (lenNext >= MIN_LEN16) begin
                     state        <= ST_IFG;
                     cnt          <= 4'd0;
                     o16_TxFrames <= o16_TxFrames + 16'd1;
                  end
               end
               ST_DRAIN: begin
                  o8_TxD <= 8'd0;
                  o_TxEN <= 1'b0;
                  o_TxER <= 1'b0;
                  if (accept && i_Last) begin
                     state <= ST_IFG;
                     cnt   <= 4'd0;
                  end
               end
               ST_IFG: begin
                  // count 0 is the octet-time still carrying the final octet
                  o8_TxD <= 8'd0;
                  o_TxEN <= 1'b0;
                  o_TxER <= 1'b0;
                  hiNib  <= 4'd0;
                  hiEn   <= 1'b0;
                  hiErr  <= 1'b0;
                  if (cnt == IFG_LAST) begin
                     state <= ST_IDLE;
                  end else begin
                     cnt   <= cnt + 4'd1;
                     phase <= ~byteMode;
                  end
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed bench for gmii_tx_framer: drives frames, captures pins each cycle and
// decodes them with a small receive model before comparing against expected frames.
module tb_gmii_tx_framer;

   logic        i_TxClk = 1'b0;
   logic        i_Reset = 1'b1;
   logic [1:0]  i2_Speed = 2'b10;
   logic [7:0]  i8_Data = 8'd0;
   logic        i_Valid = 1'b0;
   logic        i_Last = 1'b0;
   logic        i_Err = 1'b0;
   logic        o_Ready;
   logic [7:0]  o8_TxD;
   logic        o_TxEN;
   logic        o_TxER;
   logic        o_Underrun;
   logic [15:0] o16_TxFrames;

   gmii_tx_framer #(.IFG_OCTETS(12), .PAD_EN(1'b1), .MIN_LEN(60)) dut (
      .i_TxClk(i_TxClk), .i_Reset(i_Reset), .i2_Speed(i2_Speed),
      .i8_Data(i8_Data), .i_Valid(i_Valid), .i_Last(i_Last), .i_Err(i_Err),
      .o_Ready(o_Ready), .o8_TxD(o8_TxD), .o_TxEN(o_TxEN), .o_TxER(o_TxER),
      .o_Underrun(o_Underrun), .o16_TxFrames(o16_TxFrames)
   );

   always #5 i_TxClk = ~i_TxClk;

   int cyc = 0;
   always @(posedge i_TxClk) cyc <= cyc + 1;

   int         capCyc[$];
   logic [7:0] capD[$];
   bit         capEn[$];
   bit         capEr[$];
   bit         capUr[$];
   always @(negedge i_TxClk) begin
      capCyc.push_back(cyc);
      capD.push_back(o8_TxD);
      capEn.push_back(o_TxEN);
      capEr.push_back(o_TxER);
      capUr.push_back(o_Underrun);
   end

   int nChk = 0;
   int nPass = 0;
   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChk++;
      if (obs === exp) nPass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   logic [7:0] txBytes[$];
   logic [7:0] expBytes[$];
   bit         abortReq = 1'b0;
   int         frameT0;

   task automatic sendFrame(input int errIdx, input int gapAt);
      int i = 0;
      int budget = 4000;
      int n = txBytes.size();
      bit gapPending = (gapAt >= 0);
      bit first = 1'b1;
      bit willAcc;
      while (i < n && !abortReq && budget > 0) begin
         @(negedge i_TxClk);
         if (first) begin
            frameT0 = cyc;
            first = 1'b0;
         end
         if (gapPending && i == gapAt) begin
            i_Valid = 1'b0; i_Last = 1'b0; i_Err = 1'b0;
            willAcc = 1'b0;
            if (o_Ready) gapPending = 1'b0;
         end else begin
            i_Valid = 1'b1;
            i8_Data = txBytes[i];
            i_Last  = (i == n - 1);
            i_Err   = (i == errIdx);
            willAcc = o_Ready;
         end
         @(posedge i_TxClk);
         if (willAcc) i++;
         budget--;
      end
      if (budget == 0) checkVal("sendTimeout", i, n);
   endtask

   task automatic idleCycles(input int k);
      @(negedge i_TxClk);
      i_Valid = 1'b0; i_Last = 1'b0; i_Err = 1'b0;
      repeat (k) @(negedge i_TxClk);
   endtask

   // receive model results
   bit         rxPreOk;
   int         rxLen, rxStart, rxEnd, rxSfd, rxNext, rxErrCyc, rxUr, rxHiBad;
   logic [7:0] rxBytes[$];
   bit         rxErrs[$];

   task automatic parseFrame(input int from, input bit byteMode);
      int k = from;
      int e;
      logic [7:0] oct[$];
      bit oerr[$];
      rxBytes.delete(); rxErrs.delete();
      rxPreOk = 1'b0; rxLen = 0; rxErrCyc = 0; rxUr = 0; rxHiBad = 0;
      rxStart = -1; rxEnd = -1; rxSfd = -1;
      while (k < capEn.size() && !capEn[k]) k++;
      if (k >= capEn.size()) begin
         rxNext = k;
         return;
      end
      e = k;
      while (e + 1 < capEn.size() && capEn[e+1]) e++;
      rxStart = capCyc[k];
      rxEnd   = capCyc[e];
      rxNext  = e + 1;
      for (int j = k; j <= e; j++) begin
         if (capEr[j]) rxErrCyc++;
         if (capUr[j]) rxUr++;
      end
      if (byteMode) begin
         for (int j = k; j <= e; j++) begin
            oct.push_back(capD[j]);
            oerr.push_back(capEr[j]);
         end
         if (k + 7 <= e) rxSfd = capCyc[k+7];
      end else begin
         if (((e - k + 1) % 2) != 0) rxHiBad++;
         for (int j = k; j + 1 <= e; j += 2) begin
            if (capD[j][7:4] != 4'h0 || capD[j+1][7:4] != 4'h0) rxHiBad++;
            oct.push_back({capD[j+1][3:0], capD[j][3:0]});
            oerr.push_back(capEr[j] | capEr[j+1]);
         end
         if (k + 15 <= e) rxSfd = capCyc[k+15];
      end
      if (oct.size() >= 8) begin
         rxPreOk = 1'b1;
         for (int j = 0; j < 7; j++) if (oct[j] != 8'h55) rxPreOk = 1'b0;
         if (oct[7] != 8'hD5) rxPreOk = 1'b0;
         for (int j = 8; j < oct.size(); j++) begin
            rxBytes.push_back(oct[j]);
            rxErrs.push_back(oerr[j]);
         end
      end
      rxLen = rxBytes.size();
   endtask

   function automatic int cmpBytes();
      int bad = 0;
      if (rxBytes.size() != expBytes.size()) bad++;
      for (int i = 0; i < expBytes.size() && i < rxBytes.size(); i++)
         if (rxBytes[i] !== expBytes[i]) bad++;
      return bad;
   endfunction

   function automatic int firstErr();
      for (int i = 0; i < rxErrs.size(); i++) if (rxErrs[i]) return i;
      return -1;
   endfunction

   function automatic int numErrOct();
      int c = 0;
      for (int i = 0; i < rxErrs.size(); i++) if (rxErrs[i]) c++;
      return c;
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s, endA;
      logic [7:0] savedA[$];

      // reset state
      repeat (3) @(negedge i_TxClk);
      checkVal("rst_txen", o_TxEN, 1'b0);
      checkVal("rst_txd", o8_TxD, 8'h00);
      checkVal("rst_ready", o_Ready, 1'b0);
      checkVal("rst_frames", o16_TxFrames, 16'd0);
      checkVal("rst_underrun", o_Underrun, 1'b0);
      i_Reset = 1'b0;
      repeat (2) @(negedge i_TxClk);

      // byte mode, 64 octets 0x00..0x3F
      txBytes.delete();
      for (int i = 0; i < 64; i++) txBytes.push_back(8'(i));
      expBytes = txBytes;
      s = capEn.size();
      sendFrame(-1, -1);
      idleCycles(40);
      parseFrame(s, 1'b1);
      checkVal("t1_pre", rxPreOk, 1'b1);
      checkVal("t1_start", rxStart - frameT0, 1);
      checkVal("t1_sfd", rxSfd - frameT0, 8);
      checkVal("t1_len", rxLen, 64);
      checkVal("t1_data", cmpBytes(), 0);
      checkVal("t1_encyc", rxEnd - rxStart + 1, 72);
      checkVal("t1_er", rxErrCyc, 0);
      checkVal("t1_frames", o16_TxFrames, 16'd1);

      // nibble mode, 2 octets padded to 60; speed flipped mid-frame
      i2_Speed = 2'b01;
      txBytes = '{8'hA5, 8'h3C};
      expBytes = txBytes;
      for (int i = 0; i < 58; i++) expBytes.push_back(8'h00);
      s = capEn.size();
      sendFrame(-1, -1);
      i2_Speed = 2'b10;
      idleCycles(200);
      parseFrame(s, 1'b0);
      checkVal("t2_pre", rxPreOk, 1'b1);
      checkVal("t2_sfd", rxSfd - frameT0, 16);
      checkVal("t2_len", rxLen, 60);
      checkVal("t2_data", cmpBytes(), 0);
      checkVal("t2_encyc", rxEnd - rxStart + 1, 136);
      checkVal("t2_hinib", rxHiBad, 0);
      checkVal("t2_frames", o16_TxFrames, 16'd2);

      // back-to-back byte frames: padded short frame then 60 octets with error on octet 5
      txBytes = '{8'h11, 8'h22, 8'h33, 8'h44};
      savedA = txBytes;
      for (int i = 0; i < 56; i++) savedA.push_back(8'h00);
      s = capEn.size();
      sendFrame(-1, -1);
      txBytes.delete();
      for (int i = 0; i < 60; i++) txBytes.push_back(8'(i * 7 + 1));
      sendFrame(5, -1);
      idleCycles(40);
      parseFrame(s, 1'b1);
      expBytes = savedA;
      checkVal("t3a_len", rxLen, 60);
      checkVal("t3a_data", cmpBytes(), 0);
      endA = rxEnd;
      parseFrame(rxNext, 1'b1);
      expBytes = txBytes;
      checkVal("t3b_pre", rxPreOk, 1'b1);
      checkVal("t3_gap", rxStart - endA - 1, 13);
      checkVal("t3b_len", rxLen, 60);
      checkVal("t3b_data", cmpBytes(), 0);
      checkVal("t3b_ercyc", rxErrCyc, 1);
      checkVal("t3b_eridx", firstErr(), 5);
      checkVal("t3_frames", o16_TxFrames, 16'd4);

      // underrun after 10 octets of a 20-octet frame
      txBytes.delete();
      for (int i = 0; i < 20; i++) txBytes.push_back(8'(8'h80 + i));
      expBytes.delete();
      for (int i = 0; i < 10; i++) expBytes.push_back(txBytes[i]);
      expBytes.push_back(8'h00);
      s = capEn.size();
      sendFrame(-1, 10);
      idleCycles(40);
      parseFrame(s, 1'b1);
      checkVal("t4_len", rxLen, 11);
      checkVal("t4_data", cmpBytes(), 0);
      checkVal("t4_ercyc", rxErrCyc, 1);
      checkVal("t4_eridx", firstErr(), 10);
      checkVal("t4_urpulse", rxUr, 1);
      checkVal("t4_encyc", rxEnd - rxStart + 1, 19);
      checkVal("t4_frames", o16_TxFrames, 16'd4);

      // nibble mode, error on octet 5 of 64
      i2_Speed = 2'b01;
      txBytes.delete();
      for (int i = 0; i < 64; i++) txBytes.push_back(8'(i * 3 + 7));
      expBytes = txBytes;
      s = capEn.size();
      sendFrame(5, -1);
      idleCycles(60);
      parseFrame(s, 1'b0);
      checkVal("t5_len", rxLen, 64);
      checkVal("t5_data", cmpBytes(), 0);
      checkVal("t5_ercyc", rxErrCyc, 2);
      checkVal("t5_eridx", firstErr(), 5);
      checkVal("t5_eroct", numErrOct(), 1);
      checkVal("t5_frames", o16_TxFrames, 16'd5);
      i2_Speed = 2'b10;

      // reset asserted in the middle of DATA
      txBytes.delete();
      for (int i = 0; i < 64; i++) txBytes.push_back(8'(i) ^ 8'h5A);
      fork
         sendFrame(-1, -1);
         begin
            repeat (20) @(posedge i_TxClk);
            #3;
            i_Reset = 1'b1;
            #1;
            checkVal("t6_txen", o_TxEN, 1'b0);
            checkVal("t6_txd", o8_TxD, 8'h00);
            checkVal("t6_txer", o_TxER, 1'b0);
            checkVal("t6_ready", o_Ready, 1'b0);
            checkVal("t6_frames", o16_TxFrames, 16'd0);
            abortReq = 1'b1;
         end
      join
      i_Valid = 1'b0; i_Last = 1'b0; i_Err = 1'b0;
      repeat (2) @(negedge i_TxClk);
      i_Reset = 1'b0;
      abortReq = 1'b0;
      repeat (2) @(negedge i_TxClk);
      expBytes = txBytes;
      s = capEn.size();
      sendFrame(-1, -1);
      idleCycles(40);
      parseFrame(s, 1'b1);
      checkVal("t6_pre", rxPreOk, 1'b1);
      checkVal("t6_len", rxLen, 64);
      checkVal("t6_data", cmpBytes(), 0);
      checkVal("t6_frames_after", o16_TxFrames, 16'd1);

      $display("%0d/%0d checks passed", nPass, nChk);
      $finish;
   end

endmodule
